// File: rtl/l2_mem_port_arbiter.sv
// l2_mem_port_arbiter: shares the L2 memory port between miss fills and write-backs.
// One transaction at a time; read priority with bounded write starvation and RAW ordering.
module l2_mem_port_arbiter #(
   parameter int ADDR_W     = 28,
   parameter int DATA_W     = 128,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_hazard,
   output logic              rd_ready,
   output logic [DATA_W-1:0] rd_rdata,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              wb_full,
   output logic              wb_ack,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  rd_count,
   output logic [CNT_W-1:0]  wb_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state;
   logic [3:0] starve_cnt;
   logic       write_first;

   // A write jumps the queue when the FIFO is full, a pending read would
   // otherwise overtake a matching write-back, or reads have starved it.
   assign write_first = wb_req
                      & (wb_full
                         | (rd_req & rd_hazard)
                         | (starve_cnt == STARVE_LIM));

   // Completion pulses are combinational so the requester sees them
   // in the same cycle memory signals ready.
   assign rd_ready = (state == READ) & mem_ready;
   assign wb_ack   = (state == WRITE) & mem_ready;
   assign rd_rdata = mem_rdata;

   // Arbitration FSM with registered strobes, latched address/data and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         starve_cnt <= '0;
         rd_count   <= '0;
         wb_count   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (write_first) begin
                  state      <= WRITE;
                  mem_write  <= 1'b1;
                  mem_addr   <= wb_addr;
                  mem_wdata  <= wb_wdata;
                  starve_cnt <= '0;
               end else if (rd_req) begin
                  state    <= READ;
                  mem_read <= 1'b1;
                  mem_addr <= rd_addr;
                  if (!wb_req)
                     starve_cnt <= '0;
                  else if (starve_cnt != STARVE_LIM)
                     starve_cnt <= starve_cnt + 4'd1;
               end else if (wb_req) begin
                  state      <= WRITE;
                  mem_write  <= 1'b1;
                  mem_addr   <= wb_addr;
                  mem_wdata  <= wb_wdata;
                  starve_cnt <= '0;
               end else begin
                  starve_cnt <= '0;
               end
            end
            READ: begin
               if (mem_ready) begin
                  state    <= IDLE;
                  mem_read <= 1'b0;
                  rd_count <= rd_count + 1'b1;
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  state     <= IDLE;
                  mem_write <= 1'b0;
                  wb_count  <= wb_count + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_mem_port_arbiter.sv
// tb_l2_mem_port_arbiter: directed scenarios for the L2 memory port arbiter.
// Each task drives stimulus and compares against hand-computed values.
module tb_l2_mem_port_arbiter;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_hazard;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_rdata;
   logic              wb_req;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_wdata;
   logic              wb_full;
   logic              wb_ack;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic [CNT_W-1:0]  rd_count;
   logic [CNT_W-1:0]  wb_count;

   int vecs = 0;
   int errs = 0;

   l2_mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_hazard(rd_hazard),
      .rd_ready(rd_ready), .rd_rdata(rd_rdata),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
      .wb_full(wb_full), .wb_ack(wb_ack),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .rd_count(rd_count), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until a strobe is seen or the cycle budget runs out.
   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mem_read | mem_write) begin
            ok = 1'b1;
            return;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rd_req  = 1'b1;
      rd_addr = 28'h0ABCDEF;
      step();
      rd_req = 1'b0;
      #3;
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1;
      vecs++;
      if (mem_read !== 1'b0) begin
         errs++; $display("FAIL rst_mem_read got %b want 0", mem_read);
      end
      vecs++;
      if (mem_write !== 1'b0) begin
         errs++; $display("FAIL rst_mem_write got %b want 0", mem_write);
      end
      vecs++;
      if (mem_addr !== '0) begin
         errs++; $display("FAIL rst_mem_addr got %h want 0", mem_addr);
      end
      vecs++;
      if (mem_wdata !== '0) begin
         errs++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata);
      end
      vecs++;
      if (rd_ready !== 1'b0 || wb_ack !== 1'b0) begin
         errs++;
         $display("FAIL rst_pulses got rd_ready=%b wb_ack=%b want 0", rd_ready, wb_ack);
      end
      vecs++;
      if (rd_count !== 16'd0 || wb_count !== 16'd0) begin
         errs++;
         $display("FAIL rst_counts got %0d/%0d want 0/0", rd_count, wb_count);
      end
      mem_ready = 1'b0;
      #2;
      reset = 1'b0;
      step();
      vecs++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errs++; $display("FAIL rst_idle got strobes %b%b want 00", mem_read, mem_write);
      end
   endtask

   task automatic test_lone_read();
      rd_addr   = 28'h0000123;
      mem_rdata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      rd_req    = 1'b1;
      #1;
      vecs++;
      if (mem_read !== 1'b0) begin
         errs++; $display("FAIL lone_pre_strobe got %b want 0", mem_read);
      end
      step();
      vecs++;
      if (mem_read !== 1'b1 || mem_addr !== 28'h0000123) begin
         errs++;
         $display("FAIL lone_grant got rd=%b addr=%h want 1/0000123", mem_read, mem_addr);
      end
      step();
      vecs++;
      if (mem_read !== 1'b1 || rd_ready !== 1'b0) begin
         errs++;
         $display("FAIL lone_hold got rd=%b rdy=%b want 1/0", mem_read, rd_ready);
      end
      step();
      mem_ready = 1'b1;
      #1;
      vecs++;
      if (mem_read !== 1'b1 || rd_ready !== 1'b1) begin
         errs++;
         $display("FAIL lone_ready got rd=%b rdy=%b want 1/1", mem_read, rd_ready);
      end
      vecs++;
      if (rd_rdata !== 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF) begin
         errs++; $display("FAIL lone_rdata got %h want DEADBEEF..", rd_rdata);
      end
      rd_req = 1'b0;
      step();
      mem_ready = 1'b0;
      #1;
      vecs++;
      if (mem_read !== 1'b0 || rd_ready !== 1'b0 || rd_count !== 16'd1) begin
         errs++;
         $display("FAIL lone_done got rd=%b rdy=%b cnt=%0d want 0/0/1",
                  mem_read, rd_ready, rd_count);
      end
      mem_ready = 1'b1;
      step();
      step();
      mem_ready = 1'b0;
      vecs++;
      if (rd_count !== 16'd1 || wb_count !== 16'd0 || mem_read !== 1'b0) begin
         errs++;
         $display("FAIL idle_ready_ignored got cnt=%0d/%0d rd=%b want 1/0/0",
                  rd_count, wb_count, mem_read);
      end
   endtask

   task automatic test_simultaneous();
      rd_addr  = 28'h0000456;
      wb_addr  = 28'h0000789;
      wb_wdata = 128'h11112222_33334444_55556666_77778888;
      rd_req   = 1'b1;
      wb_req   = 1'b1;
      step();
      vecs++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000456) begin
         errs++;
         $display("FAIL sim_read_first got rd=%b wr=%b addr=%h want 1/0/0000456",
                  mem_read, mem_write, mem_addr);
      end
      mem_ready = 1'b1;
      #1;
      vecs++;
      if (rd_ready !== 1'b1 || wb_ack !== 1'b0) begin
         errs++;
         $display("FAIL sim_rd_pulse got rdy=%b ack=%b want 1/0", rd_ready, wb_ack);
      end
      rd_req = 1'b0;
      step();
      mem_ready = 1'b0;
      vecs++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errs++;
         $display("FAIL sim_gap got rd=%b wr=%b want 0/0", mem_read, mem_write);
      end
      step();
      vecs++;
      if (mem_write !== 1'b1 || mem_addr !== 28'h0000789 ||
          mem_wdata !== 128'h11112222_33334444_55556666_77778888) begin
         errs++;
         $display("FAIL sim_write got wr=%b addr=%h data=%h", mem_write, mem_addr, mem_wdata);
      end
      wb_addr = 28'h0FFFFFF;
      step();
      vecs++;
      if (mem_addr !== 28'h0000789 || wb_ack !== 1'b0) begin
         errs++;
         $display("FAIL sim_latched got addr=%h ack=%b want 0000789/0", mem_addr, wb_ack);
      end
      mem_ready = 1'b1;
      #1;
      vecs++;
      if (wb_ack !== 1'b1) begin
         errs++; $display("FAIL sim_ack got %b want 1", wb_ack);
      end
      wb_req = 1'b0;
      step();
      mem_ready = 1'b0;
      #1;
      vecs++;
      if (wb_ack !== 1'b0 || mem_write !== 1'b0 ||
          wb_count !== 16'd1 || rd_count !== 16'd2) begin
         errs++;
         $display("FAIL sim_done got ack=%b wr=%b cnt=%0d/%0d want 0/0/2/1",
                  wb_ack, mem_write, rd_count, wb_count);
      end
   endtask

   task automatic test_starvation();
      string exp_seq;
      byte   g;
      bit    ok;
      exp_seq  = "RRRRWRRRRW";
      rd_addr  = 28'h0000AAA;
      wb_addr  = 28'h0000BBB;
      rd_req   = 1'b1;
      wb_req   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_grant(ok);
         vecs++;
         if (!ok) begin
            errs++; $display("FAIL starve_timeout at grant %0d", i);
            break;
         end
         g = mem_read ? "R" : "W";
         vecs++;
         if (g !== exp_seq[i]) begin
            errs++;
            $display("FAIL starve_order[%0d] got %c want %c", i, g, exp_seq[i]);
         end
         mem_ready = 1'b1;
         step();
         mem_ready = 1'b0;
      end
      rd_req = 1'b0;
      wb_req = 1'b0;
      step();
      vecs++;
      if (rd_count !== 16'd10 || wb_count !== 16'd3) begin
         errs++;
         $display("FAIL starve_counts got %0d/%0d want 10/3", rd_count, wb_count);
      end
   endtask

   task automatic test_hazard_full();
      bit ok;
      rd_addr   = 28'h0000CCC;
      wb_addr   = 28'h0000CCC;
      rd_req    = 1'b1;
      rd_hazard = 1'b1;
      wb_req    = 1'b1;
      step();
      vecs++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
         errs++;
         $display("FAIL hazard_write_first got rd=%b wr=%b want 0/1", mem_read, mem_write);
      end
      mem_ready = 1'b1;
      wb_req    = 1'b0;
      step();
      mem_ready = 1'b0;
      step();
      vecs++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
         errs++;
         $display("FAIL hazard_no_wb got rd=%b wr=%b want 1/0", mem_read, mem_write);
      end
      mem_ready = 1'b1;
      rd_req    = 1'b0;
      rd_hazard = 1'b0;
      step();
      mem_ready = 1'b0;
      rd_req    = 1'b1;
      wb_req    = 1'b1;
      wb_full   = 1'b1;
      wait_grant(ok);
      vecs++;
      if (!ok || mem_write !== 1'b1 || mem_read !== 1'b0) begin
         errs++;
         $display("FAIL full_write_first got ok=%b rd=%b wr=%b want 1/0/1",
                  ok, mem_read, mem_write);
      end
      mem_ready = 1'b1;
      wb_req    = 1'b0;
      wb_full   = 1'b0;
      step();
      mem_ready = 1'b0;
      wait_grant(ok);
      mem_ready = 1'b1;
      rd_req    = 1'b0;
      step();
      mem_ready = 1'b0;
      step();
      vecs++;
      if (rd_count !== 16'd12 || wb_count !== 16'd5) begin
         errs++;
         $display("FAIL hazard_counts got %0d/%0d want 12/5", rd_count, wb_count);
      end
   endtask

   task automatic test_reset_write();
      bit ok;
      wb_addr  = 28'h0000DDD;
      wb_wdata = 128'hCAFE;
      wb_req   = 1'b1;
      step();
      vecs++;
      if (mem_write !== 1'b1) begin
         errs++; $display("FAIL rw_grant got %b want 1", mem_write);
      end
      step();
      #3;
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1;
      vecs++;
      if (mem_write !== 1'b0 || wb_ack !== 1'b0 || wb_count !== 16'd0) begin
         errs++;
         $display("FAIL rw_abort got wr=%b ack=%b cnt=%0d want 0/0/0",
                  mem_write, wb_ack, wb_count);
      end
      mem_ready = 1'b0;
      wb_req    = 1'b0;
      #2;
      reset = 1'b0;
      step();
      rd_addr = 28'h0000EEE;
      rd_req  = 1'b1;
      wait_grant(ok);
      vecs++;
      if (!ok || mem_read !== 1'b1 || mem_addr !== 28'h0000EEE) begin
         errs++;
         $display("FAIL rw_next_read got ok=%b rd=%b addr=%h", ok, mem_read, mem_addr);
      end
      mem_ready = 1'b1;
      #1;
      vecs++;
      if (rd_ready !== 1'b1) begin
         errs++; $display("FAIL rw_rd_ready got %b want 1", rd_ready);
      end
      rd_req = 1'b0;
      step();
      mem_ready = 1'b0;
      vecs++;
      if (rd_count !== 16'd1 || wb_count !== 16'd0 || mem_read !== 1'b0) begin
         errs++;
         $display("FAIL rw_counts got %0d/%0d rd=%b want 1/0/0",
                  rd_count, wb_count, mem_read);
      end
   endtask

   initial begin
      reset     = 1'b1;
      rd_req    = 1'b0;
      rd_addr   = '0;
      rd_hazard = 1'b0;
      wb_req    = 1'b0;
      wb_addr   = '0;
      wb_wdata  = '0;
      wb_full   = 1'b0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      step();
      test_reset();
      test_lone_read();
      test_simultaneous();
      test_starvation();
      test_hazard_full();
      test_reset_write();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
